// File: rtl/cpi_muldiv_if.sv
// rtl/cpi_muldiv_if.sv - coprocessor request/response bundle between cpu and responder
interface cpi_muldiv_if;
  logic        cpi_valid;
  logic [31:0] cpi_inst;
  logic [31:0] cpi_r1;
  logic [31:0] cpi_r2;
  logic        cpi_ready;
  logic        cpi_wait;
  logic [31:0] cpi_data;
  logic        cpi_drop;

  modport master (
    output cpi_valid, cpi_inst, cpi_r1, cpi_r2,
    input  cpi_ready, cpi_wait, cpi_data, cpi_drop
  );

  modport slave (
    input  cpi_valid, cpi_inst, cpi_r1, cpi_r2,
    output cpi_ready, cpi_wait, cpi_data, cpi_drop
  );
endinterface

// File: rtl/cpi_muldiv.sv
// rtl/cpi_muldiv.sv - iterative 32-bit multiply/divide coprocessor responder
module cpi_muldiv #(
  parameter logic [3:0] OPCODE     = 4'h6,
  parameter bit         DIV_ENABLE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  cpi_muldiv_if.slave   cpi
);

  typedef enum logic [1:0] {IDLE, CALC, DONE, RELEASE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [1:0]  subop;
  logic [31:0] op_a;
  logic [31:0] op_b;
  // acc_hi doubles as the partial remainder, acc_lo as multiplier / dividend-quotient
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;

  logic        ready_q;
  logic        wait_q;
  logic        drop_q;
  logic [31:0] data_q;

  logic        is_ours;
  logic        subop_ok;
  logic        unused_inst;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_sh;
  logic [33:0] div_diff;
  logic        div_bit;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] result;

  assign is_ours     = cpi.cpi_valid && (cpi.cpi_inst[31:28] == OPCODE);
  assign subop_ok    = (cpi.cpi_inst[27:26] == 2'b00) && (DIV_ENABLE || !cpi.cpi_inst[25]);
  assign unused_inst = ^cpi.cpi_inst[23:0];

  // One radix-2 step of both datapaths; the step result also feeds the final answer so the
  // last iteration and the response share a clock edge.
  always_comb begin
    mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_a} : 33'd0);
    mul_next = {mul_sum, acc_lo[31:1]};
    div_sh   = {acc_hi, acc_lo[31]};
    div_diff = {1'b0, div_sh} - {2'b00, op_b};
    div_bit  = ~div_diff[33];
    rem_next = div_bit ? div_diff[31:0] : div_sh[31:0];
    quo_next = {acc_lo[30:0], div_bit};
    case (subop)
      2'd0:    result = mul_next[31:0];
      2'd1:    result = mul_next[63:32];
      2'd2:    result = quo_next;
      default: result = rem_next;
    endcase
  end

  // Request FSM with registered response; a zero divisor falls out of the restoring
  // algorithm naturally (quotient all ones, remainder equals the dividend).
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      subop   <= 2'd0;
      op_a    <= 32'd0;
      op_b    <= 32'd0;
      acc_hi  <= 32'd0;
      acc_lo  <= 32'd0;
      ready_q <= 1'b0;
      wait_q  <= 1'b0;
      drop_q  <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_ours) begin
            op_a  <= cpi.cpi_r1;
            op_b  <= cpi.cpi_r2;
            subop <= cpi.cpi_inst[25:24];
            if (subop_ok) begin
              state  <= CALC;
              wait_q <= 1'b1;
              cnt    <= 5'd31;
              acc_hi <= 32'd0;
              acc_lo <= cpi.cpi_inst[25] ? cpi.cpi_r1 : cpi.cpi_r2;
            end else begin
              state   <= DONE;
              ready_q <= 1'b1;
              drop_q  <= 1'b0;
              data_q  <= 32'd0;
            end
          end
        end
        CALC: begin
          if (!cpi.cpi_valid) begin
            state  <= IDLE;
            wait_q <= 1'b0;
          end else begin
            if (subop[1]) begin
              acc_hi <= rem_next;
              acc_lo <= quo_next;
            end else begin
              {acc_hi, acc_lo} <= mul_next;
            end
            if (cnt == 5'd0) begin
              state   <= DONE;
              ready_q <= 1'b1;
              drop_q  <= 1'b1;
              data_q  <= result;
              wait_q  <= 1'b0;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          drop_q  <= 1'b0;
          data_q  <= 32'd0;
          state   <= RELEASE;
        end
        default: begin
          if (!cpi.cpi_valid) state <= IDLE;
        end
      endcase
    end
  end

  assign cpi.cpi_ready = ready_q;
  assign cpi.cpi_wait  = wait_q;
  assign cpi.cpi_drop  = drop_q;
  assign cpi.cpi_data  = data_q;

endmodule

// File: tb/tb_cpi_muldiv.sv
// tb/tb_cpi_muldiv.sv - scoreboard bench for the multiply/divide coprocessor
module tb_cpi_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;

  // free-running clock
  always #5 clk = ~clk;

  cpi_muldiv_if bus ();
  cpi_muldiv_if bus_nd ();

  cpi_muldiv #(.OPCODE(4'h6), .DIV_ENABLE(1'b1)) u_dut (
    .clk (clk),
    .rst (rst),
    .cpi (bus.slave)
  );

  cpi_muldiv #(.OPCODE(4'h6), .DIV_ENABLE(1'b0)) u_dut_nd (
    .clk (clk),
    .rst (rst),
    .cpi (bus_nd.slave)
  );

  int vec_cnt   = 0;
  int err_cnt   = 0;
  int ready_cnt = 0;
  logic [32:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] sub, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (sub)
      4'd0:    return p[31:0];
      4'd1:    return p[63:32];
      4'd2:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd3:    return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  // response monitor: pops the scoreboard on every ready pulse, checks quiet outputs otherwise
  always @(negedge clk) begin
    logic [32:0] exp;
    if (!rst) begin
      if (bus.cpi_ready) begin
        ready_cnt++;
        if (sb_q.size() == 0) begin
          check_eq("spurious_ready", 64'd1, 64'd0);
        end else begin
          exp = sb_q.pop_front();
          check_eq("resp_data", {32'd0, bus.cpi_data}, {32'd0, exp[31:0]});
          check_eq("resp_drop", {63'd0, bus.cpi_drop}, {63'd0, exp[32]});
        end
      end else begin
        check_eq("quiet_out", {31'd0, bus.cpi_drop, bus.cpi_data}, 64'd0);
      end
    end
  end

  task automatic run_op(input logic [3:0] sub, input logic [31:0] a, input logic [31:0] b,
                        input int hold_extra, input string tag);
    int n;
    int waits;
    int rc0;
    bit seen;
    bit supported;
    supported = (sub < 4'd4);
    @(posedge clk); #1;
    bus.cpi_valid = 1'b1;
    bus.cpi_inst  = {4'h6, sub, 24'h123456};
    bus.cpi_r1    = a;
    bus.cpi_r2    = b;
    sb_q.push_back({supported, model(sub, a, b)});
    rc0 = ready_cnt; n = 0; waits = 0; seen = 1'b0;
    while (!seen && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (bus.cpi_ready) seen = 1'b1;
      else if (bus.cpi_wait) waits++;
      if (n == 1) begin
        bus.cpi_r1 = $urandom;
        bus.cpi_r2 = $urandom;
      end
    end
    check_eq({tag, "_latency"}, n, supported ? 64'd33 : 64'd1);
    check_eq({tag, "_wait_cycles"}, waits, supported ? 64'd32 : 64'd0);
    if (!seen) sb_q.delete();
    repeat (1 + hold_extra) @(posedge clk);
    #1;
    bus.cpi_valid = 1'b0;
    bus.cpi_inst  = 32'd0;
    @(posedge clk); #1;
    check_eq({tag, "_pulses"}, ready_cnt - rc0, seen ? 64'd1 : 64'd0);
  endtask

  initial begin
    int rdy;
    int n;
    logic [3:0] rs;
    logic [31:0] ra;
    logic [31:0] rb;

    bus.cpi_valid = 1'b0; bus.cpi_inst = 32'd0; bus.cpi_r1 = 32'd0; bus.cpi_r2 = 32'd0;
    bus_nd.cpi_valid = 1'b0; bus_nd.cpi_inst = 32'd0; bus_nd.cpi_r1 = 32'd0; bus_nd.cpi_r2 = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_out", {bus.cpi_ready, bus.cpi_wait, bus.cpi_drop, bus.cpi_data}, 64'd0);
    check_eq("reset_out_nd", {bus_nd.cpi_ready, bus_nd.cpi_wait, bus_nd.cpi_drop, bus_nd.cpi_data}, 64'd0);
    rst = 1'b0;

    run_op(4'd0, 32'd7, 32'd6, 0, "mul_7x6");
    run_op(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhu_max");
    run_op(4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_max");
    run_op(4'd2, 32'd100, 32'd7, 0, "divu_100_7");
    run_op(4'd3, 32'd100, 32'd7, 0, "remu_100_7");
    run_op(4'd2, 32'h1234_5678, 32'd0, 0, "divu_by0");
    run_op(4'd3, 32'd5, 32'd0, 0, "remu_by0");
    run_op(4'hF, 32'd1, 32'd2, 0, "bad_subop");
    run_op(4'd0, 32'd9, 32'd9, 3, "hold_valid");

    for (int i = 0; i < 8; i++) begin
      rs = 4'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 5) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      run_op(rs, ra, rb, i % 3, "random_op");
    end

    // foreign opcode: never claimed
    @(posedge clk); #1;
    bus.cpi_valid = 1'b1; bus.cpi_inst = {4'h7, 4'h0, 24'd0}; bus.cpi_r1 = 32'd7; bus.cpi_r2 = 32'd6;
    repeat (40) begin
      @(posedge clk); #1;
      check_eq("foreign_out", {bus.cpi_ready, bus.cpi_wait, bus.cpi_drop, bus.cpi_data}, 64'd0);
    end
    bus.cpi_valid = 1'b0; bus.cpi_inst = 32'd0;

    // abandoned request mid-calculation
    @(posedge clk); #1;
    bus.cpi_valid = 1'b1; bus.cpi_inst = {4'h6, 4'h0, 24'd0}; bus.cpi_r1 = 32'd11; bus.cpi_r2 = 32'd13;
    repeat (10) @(posedge clk);
    #1;
    check_eq("abandon_wait_busy", {63'd0, bus.cpi_wait}, 64'd1);
    bus.cpi_valid = 1'b0; bus.cpi_inst = 32'd0;
    @(posedge clk); #1;
    check_eq("abandon_wait_clear", {63'd0, bus.cpi_wait}, 64'd0);
    rdy = 0;
    repeat (40) begin
      @(posedge clk); #1;
      rdy += int'(bus.cpi_ready);
    end
    check_eq("abandon_no_ready", rdy, 64'd0);

    // reset mid-calculation
    @(posedge clk); #1;
    bus.cpi_valid = 1'b1; bus.cpi_inst = {4'h6, 4'h0, 24'd0}; bus.cpi_r1 = 32'd7; bus.cpi_r2 = 32'd6;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_calc", {bus.cpi_ready, bus.cpi_wait, bus.cpi_drop, bus.cpi_data}, 64'd0);
    rst = 1'b0;
    bus.cpi_valid = 1'b0; bus.cpi_inst = 32'd0;
    @(posedge clk);
    run_op(4'd0, 32'd3, 32'd5, 0, "mul_after_rst");

    // divide disabled: DIVU is an unsupported subop
    @(posedge clk); #1;
    bus_nd.cpi_valid = 1'b1; bus_nd.cpi_inst = {4'h6, 4'h2, 24'd0};
    bus_nd.cpi_r1 = 32'd100; bus_nd.cpi_r2 = 32'd7;
    n = 0;
    while (!bus_nd.cpi_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (!bus_nd.cpi_ready)
        check_eq("nodiv_wait", {63'd0, bus_nd.cpi_wait}, 64'd0);
    end
    check_eq("nodiv_latency", n, 64'd1);
    check_eq("nodiv_resp", {bus_nd.cpi_wait, bus_nd.cpi_drop, bus_nd.cpi_data}, 64'd0);
    @(posedge clk); #1;
    bus_nd.cpi_valid = 1'b0; bus_nd.cpi_inst = 32'd0;
    @(posedge clk); #1;
    check_eq("nodiv_idle", {bus_nd.cpi_ready, bus_nd.cpi_wait, bus_nd.cpi_drop, bus_nd.cpi_data}, 64'd0);

    repeat (2) @(posedge clk);
    #1;
    check_eq("scoreboard_drained", sb_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
